password_check: RTL and testbench

PASSWORD_CHECK -- requirements
Module: password_check

---
 rtl/password_check_pkg.sv | 18 +
 rtl/seg7_decode.sv | 14 +
 rtl/password_check.sv | 142 ++++++++++++++
 tb/tb_password_check.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/password_check_pkg.sv
// rtl/password_check_pkg.sv - shared state encoding and display constants for password_check
package password_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_DEFUSED,
    ST_EXPLODED
  } state_t;

  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
  };

  localparam logic [7:0] CAT_DISP0 = 8'hFE;
  localparam logic [7:0] CAT_OFF   = 8'hFF;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - 4-bit value to active-high 7-segment pattern, blank above 9
module seg7_decode
  import password_check_pkg::*;
(
  input  logic [3:0] value,
  output logic [7:0] seg
);

  always_comb begin
    seg = 8'h00;
    if (value <= 4'd9) seg = SEG_DIGIT[value];
  end

endmodule

// File: rtl/password_check.sv
// rtl/password_check.sv - timed password entry with limited tries, defuse/explode outcome
module password_check
  import password_check_pkg::*;
#(
  parameter int TICK_DIV   = 500,
  parameter int ENTRY_SECS = 9,
  parameter int MAX_TRIES  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       endOfShow,
  input  logic [6:0] psw,
  input  logic [6:0] sw,
  input  logic       btn,
  output logic [6:0] LD,
  output logic [7:0] seg,
  output logic [7:0] cat,
  output logic       defused,
  output logic       exploded
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [3:0]     secs, secs_n;
  logic [2:0]     tries, tries_n;
  logic [6:0]     pw_q, pw_n;
  logic           btn_q;
  logic           blink_q, blink_n;
  logic           tick, confirm, match;
  logic [3:0]     digit_val;
  logic [7:0]     digit_seg;

  assign tick    = (cnt == TICK_LAST);
  assign confirm = btn & ~btn_q;
  assign match   = (sw == pw_q);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    secs_n  = secs;
    tries_n = tries;
    pw_n    = pw_q;
    blink_n = blink_q;
    case (state)
      ST_IDLE: begin
        if (endOfShow) begin
          state_n = ST_ENTRY;
          pw_n    = psw;
          secs_n  = 4'(ENTRY_SECS);
          cnt_n   = '0;
          tries_n = 3'(MAX_TRIES);
        end
      end
      ST_ENTRY: begin
        cnt_n = tick ? '0 : cnt + 1'b1;
        if (tick) secs_n = secs - 4'd1;
        if (confirm) tries_n = match ? tries : tries - 3'd1;
        // The confirm decision wins over a final tick landing on the same edge.
        if (confirm && match) begin
          state_n = ST_DEFUSED;
        end else if ((confirm && tries == 3'd1) || (tick && secs == 4'd1)) begin
          state_n = ST_EXPLODED;
          cnt_n   = '0;
          blink_n = 1'b1;
        end
      end
      ST_DEFUSED: begin
      end
      ST_EXPLODED: begin
        // The second tick keeps running here purely to pace the LED blink.
        cnt_n = tick ? '0 : cnt + 1'b1;
        if (tick) blink_n = ~blink_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      secs    <= '0;
      tries   <= '0;
      pw_q    <= '0;
      btn_q   <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      secs    <= secs_n;
      tries   <= tries_n;
      pw_q    <= pw_n;
      btn_q   <= btn;
      blink_q <= blink_n;
    end
  end

  assign digit_val = (state == ST_ENTRY) ? secs : 4'd0;

  seg7_decode u_seg7_decode (
    .value (digit_val),
    .seg   (digit_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      LD       <= '0;
      seg      <= '0;
      cat      <= CAT_OFF;
      defused  <= 1'b0;
      exploded <= 1'b0;
    end else begin
      defused  <= (state == ST_DEFUSED);
      exploded <= (state == ST_EXPLODED);
      case (state)
        ST_IDLE: begin
          LD  <= '0;
          seg <= '0;
          cat <= CAT_OFF;
        end
        ST_ENTRY: begin
          LD  <= sw;
          seg <= digit_seg;
          cat <= CAT_DISP0;
        end
        ST_DEFUSED: begin
          LD  <= 7'h7F;
          seg <= digit_seg;
          cat <= CAT_DISP0;
        end
        ST_EXPLODED: begin
          LD  <= blink_q ? 7'h7F : 7'h00;
          seg <= '0;
          cat <= CAT_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_password_check.sv
// tb/tb_password_check.sv - scoreboard bench for password_check against an elapsed-time model
module tb_password_check;

  localparam int TD = 4;
  localparam int ES = 3;
  localparam int MT = 2;

  typedef struct {
    logic [6:0] ld;
    logic [7:0] seg;
    logic [7:0] cat;
    logic       d;
    logic       x;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       endOfShow = 1'b0;
  logic       btn = 1'b0;
  logic [6:0] psw = '0;
  logic [6:0] sw = '0;
  logic [6:0] LD;
  logic [7:0] seg;
  logic [7:0] cat;
  logic       defused;
  logic       exploded;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  logic [7:0] digit_tab [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                  8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  // model: 0 idle, 1 entry, 2 defused, 3 exploded; k = edges spent in entry
  int         mode = 0;
  int         k = 0;
  int         wrong = 0;
  int         ex_k = 0;
  logic [6:0] m_pw = '0;
  logic       m_prev_btn = 1'b0;

  always #5 clk = ~clk;

  password_check #(.TICK_DIV(TD), .ENTRY_SECS(ES), .MAX_TRIES(MT)) dut (
    .clk       (clk),
    .rst       (rst),
    .endOfShow (endOfShow),
    .psw       (psw),
    .sw        (sw),
    .btn       (btn),
    .LD        (LD),
    .seg       (seg),
    .cat       (cat),
    .defused   (defused),
    .exploded  (exploded)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    exp_t e;
    logic conf;
    if (!rst) begin
      e.ld = 7'h00; e.seg = 8'h00; e.cat = 8'hFF; e.d = 1'b0; e.x = 1'b0;
      exp_q.push_back(e);
      mode = 0; m_prev_btn = 1'b0; m_pw = '0;
      return;
    end
    e.d = 1'b0; e.x = 1'b0;
    case (mode)
      1: begin e.ld = sw; e.seg = digit_tab[ES - k / TD]; e.cat = 8'hFE; end
      2: begin e.ld = 7'h7F; e.seg = 8'h3F; e.cat = 8'hFE; e.d = 1'b1; end
      3: begin
        e.ld = (((ex_k / TD) % 2) == 0) ? 7'h7F : 7'h00;
        e.seg = 8'h00; e.cat = 8'hFF; e.x = 1'b1;
      end
      default: begin e.ld = 7'h00; e.seg = 8'h00; e.cat = 8'hFF; end
    endcase
    exp_q.push_back(e);

    conf = btn && !m_prev_btn;
    m_prev_btn = btn;
    case (mode)
      0: if (endOfShow) begin mode = 1; m_pw = psw; k = 0; wrong = 0; end
      1: begin
        k++;
        if (conf && sw == m_pw) mode = 2;
        else begin
          if (conf) wrong++;
          if (wrong >= MT || k >= ES * TD) begin mode = 3; ex_k = 0; end
        end
      end
      3: ex_k++;
      default: ;
    endcase
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; endOfShow = 1'b0; btn = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("LD", {1'b0, LD}, {1'b0, e.ld});
      chk("seg", seg, e.seg);
      chk("cat", cat, e.cat);
      chk("defused", {7'b0, defused}, {7'b0, e.d});
      chk("exploded", {7'b0, exploded}, {7'b0, e.x});
    end
  end

  initial begin
    logic [6:0] p;
    step(3);

    // correct entry
    rst = 1'b1; endOfShow = 1'b1; psw = 7'h55; sw = 7'h00;
    step(1);
    sw = 7'h55; step(2);
    btn = 1'b1; step(1);
    btn = 1'b0; step(2);
    chk("s1_defused", {7'b0, defused}, 8'd1);
    chk("s1_LD", {1'b0, LD}, 8'h7F);
    chk("s1_seg", seg, 8'h3F);

    // timeout
    do_reset();
    endOfShow = 1'b1; psw = 7'($urandom); sw = ~psw;
    step(1);
    step(12);
    chk("s2_not_yet", {7'b0, exploded}, 8'd0);
    step(1);
    chk("s2_exploded", {7'b0, exploded}, 8'd1);
    chk("s2_cat", cat, 8'hFF);

    // tries exhausted
    do_reset();
    psw = 7'h55; sw = 7'h00; endOfShow = 1'b1;
    step(2);
    btn = 1'b1; step(1);
    btn = 1'b0; step(1);
    chk("s3_first_try", {7'b0, exploded}, 8'd0);
    chk("s3_cat", cat, 8'hFE);
    btn = 1'b1; step(1);
    btn = 1'b0; step(1);
    chk("s3_exploded", {7'b0, exploded}, 8'd1);

    // held button consumes one try
    do_reset();
    psw = 7'h55; sw = 7'h01; endOfShow = 1'b1;
    step(1);
    btn = 1'b1; step(10);
    btn = 1'b0; step(1);
    chk("s4_held", {7'b0, exploded}, 8'd0);
    chk("s4_cat", cat, 8'hFE);
    step(3);

    // matching confirm on the final tick
    do_reset();
    p = 7'($urandom); psw = p; sw = p; endOfShow = 1'b1;
    step(1);
    step(11);
    btn = 1'b1; step(1);
    btn = 1'b0; step(2);
    chk("s5_defused", {7'b0, defused}, 8'd1);
    chk("s5_exploded", {7'b0, exploded}, 8'd0);

    // reset mid-entry
    do_reset();
    endOfShow = 1'b1; psw = 7'($urandom);
    step(1);
    endOfShow = 1'b0; step(5);
    rst = 1'b0; step(1);
    rst = 1'b1;
    chk("s6_LD", {1'b0, LD}, 8'h00);
    chk("s6_seg", seg, 8'h00);
    chk("s6_cat", cat, 8'hFF);
    step(2);
    chk("s6_idle_cat", cat, 8'hFF);
    endOfShow = 1'b1; step(2);
    chk("s6_restart_seg", seg, 8'h4F);

    // randomized traffic
    repeat (600) begin
      rst = ($urandom_range(0, 39) != 0);
      endOfShow = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) psw = 7'($urandom);
      sw = $urandom_range(0, 1) ? psw : 7'($urandom);
      btn = ($urandom_range(0, 2) == 0);
      step(1);
    end
    step(2);
    #6;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
